// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, clock/baud
// defaults and the arbiter state encoding.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int CLK_HZ      = 27_000_000;
    localparam int BAUD        = 115_200;

    // Watchdog default is 100 ms of system clock; BIT_CYCLES is one UART bit time.
    localparam int DEFAULT_TIMEOUT_CYCLES = CLK_HZ / 10;
    localparam int BIT_CYCLES             = CLK_HZ / BAUD;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority pick: returns the first valid requester at or after
// rr_ptr (wrapping), plus a flag saying whether any requester is valid.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      winner,
    output logic               any
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx = IW'((32'(rr_ptr) + j) % NUM_REQ);
            if (!any && req_valid[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a byte-level UART transmitter.
// Optional stall watchdog enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e             state, state_next;
    logic [IW-1:0]          owner, rr_ptr, ptr_after_owner, winner;
    logic                   any_req, xfer, last_xfer, wd_fire;
    logic [UART_BYTE_W-1:0] req_bytes [NUM_REQ];

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any       (any_req)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    always_comb begin
        xfer            = (state == SEND) && req_valid[owner] && tx_ready;
        last_xfer       = xfer && req_last[owner];
        ptr_after_owner = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wd_cnt;

    assign wd_fire = (state == SEND) && !xfer && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || state != SEND || xfer || wd_fire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)              state_next = SEND;
            SEND:    if (last_xfer || wd_fire) state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Outputs are forced low during reset even if the state is still SEND.
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        grant     = '0;
        busy      = 1'b0;
        timeout   = 1'b0;
        if (!rst && state == SEND) begin
            grant[owner]     = 1'b1;
            busy             = 1'b1;
            tx_valid         = req_valid[owner];
            tx_data          = req_bytes[owner];
            req_ready[owner] = tx_ready;
            timeout          = wd_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                owner <= winner;
            end
            if (last_xfer || wd_fire) begin
                rr_ptr <= ptr_after_owner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level reference model,
// per-cycle output compare, directed scenarios plus randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int T = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int BP_PERIOD = 12;
`else
    localparam int BP_PERIOD = 234;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready, busy, timeout;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Per-requester byte queues: bit 8 marks the last byte of a packet.
    logic [8:0]   pq [N][$];
    int           m_owner, m_ptr, m_stall;
    int           checks, failures, cyc, dut_bytes, model_bytes, vprob, txmode;
    logic [N-1:0] acc;

    logic [N-1:0] h_grant [$];
    logic         h_busy  [$];
    logic         h_xfer  [$];
    logic         h_to    [$];
    logic [7:0]   h_data  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pending();
        int n = (m_owner >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) n += pq[i].size();
        return n;
    endfunction

    task automatic clear_hist();
        h_grant.delete(); h_busy.delete(); h_xfer.delete(); h_to.delete(); h_data.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() == 0) begin
                req_valid[i]       = 1'b0;
                req_last[i]        = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end else if (!req_valid[i] || acc[i]) begin
                req_valid[i] = ($urandom_range(99) < vprob);
                {req_last[i], req_data[i*8 +: 8]} = pq[i][0];
            end
        end
        case (txmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(1));
            default: tx_ready = ((cyc % BP_PERIOD) == 0);
        endcase
    endtask

    task automatic cycle();
        logic [N-1:0] e_rr, e_gr;
        logic         e_tv, e_busy, e_to, xfer, last;
        logic [7:0]   e_td;
        @(negedge clk);
        e_rr = '0; e_gr = '0; e_tv = 1'b0; e_td = 8'h00; e_busy = 1'b0; e_to = 1'b0; xfer = 1'b0;
        if (!rst && m_owner >= 0) begin
            e_gr[m_owner]   = 1'b1;
            e_busy          = 1'b1;
            e_tv            = req_valid[m_owner];
            e_td            = req_data[m_owner*8 +: 8];
            e_rr[m_owner]   = tx_ready;
            xfer            = req_valid[m_owner] && tx_ready;
`ifdef UART_ARB_TIMEOUT_EN
            e_to            = !xfer && (m_stall == T - 1);
`endif
        end
        chk("grant",     32'(grant),     32'(e_gr));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("tx_valid",  32'(tx_valid),  32'(e_tv));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("timeout",   32'(timeout),   32'(e_to));
        if (e_tv) chk("tx_data", 32'(tx_data), 32'(e_td));
        h_grant.push_back(grant);
        h_busy.push_back(busy);
        h_xfer.push_back(tx_valid && tx_ready);
        h_to.push_back(timeout);
        h_data.push_back(tx_data);
        if (tx_valid && tx_ready) dut_bytes++;

        @(posedge clk);
        acc = '0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_stall = 0;
        end else if (m_owner < 0) begin
            for (int j = 0; j < N; j++)
                if (m_owner < 0 && req_valid[(m_ptr + j) % N]) m_owner = (m_ptr + j) % N;
            m_stall = 0;
        end else if (xfer) begin
            acc[m_owner] = 1'b1;
            last = 1'b0;
            if (pq[m_owner].size() > 0) begin
                last = pq[m_owner][0][8];
                void'(pq[m_owner].pop_front());
            end
            model_bytes++;
            m_stall = 0;
            if (last) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            if (m_stall == T - 1) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_stall = 0;
            end else begin
                m_stall++;
            end
`endif
        end
        cyc++;
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (pending() > 0 && n < bound) begin
            cycle();
            n++;
        end
        chk(name, 32'(pending()), 32'd0);
    endtask

    logic [N-1:0] rr_exp [16] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                                  4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};

    initial begin
        int start, n, hold_cnt, len;
        checks = 0; failures = 0; cyc = 0; dut_bytes = 0; model_bytes = 0;
        m_owner = -1; m_ptr = 0; m_stall = 0;
        acc = '0; vprob = 100; txmode = 0;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;

        // Reset state
        clear_hist();
        do_reset(3);
        chk("reset_grant", 32'(h_grant[2]), 32'd0);
        chk("reset_busy",  32'(h_busy[2]),  32'd0);

        // Single source "Hi\n" from requester 1
        pq[1].push_back(9'h048); pq[1].push_back(9'h069); pq[1].push_back(9'h10A);
        drive();
        clear_hist();
        repeat (6) cycle();
        chk("hi_idle_grant", 32'(h_grant[0]), 32'd0);
        chk("hi_grant",      32'(h_grant[1]), 32'h2);
        chk("hi_xfers",      32'({h_xfer[1], h_xfer[2], h_xfer[3]}), 32'h7);
        chk("hi_byte0",      32'(h_data[1]), 32'h48);
        chk("hi_byte1",      32'(h_data[2]), 32'h69);
        chk("hi_byte2",      32'(h_data[3]), 32'h0A);
        chk("hi_busy_last",  32'(h_busy[3]), 32'd1);
        chk("hi_busy_fall",  32'(h_busy[4]), 32'd0);

        // Round robin from reset, all four requesters with 2-byte packets
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            pq[i].push_back(9'(8'h10 * i + 1));
            pq[i].push_back(9'(9'h100 | (8'h10 * i + 2)));
        end
        pq[0].push_back(9'h0E1); pq[0].push_back(9'h1E2);
        drive();
        clear_hist();
        repeat (16) cycle();
        for (int k = 0; k < 16; k++) chk("rr_grant", 32'(h_grant[k]), 32'(rr_exp[k]));

        // Backpressure: sparse tx_ready, requesters 0, 2, 3 contending
        txmode = 2;
        for (int b = 0; b < 5; b++) pq[2].push_back(9'((b == 4 ? 9'h100 : 9'h0) | 9'(8'hA0 + b)));
        pq[0].push_back(9'h0C0); pq[0].push_back(9'h1C1);
        pq[3].push_back(9'h1D0);
        drive();
        drain("bp_drain", 12000);

        // Reset mid-packet: requester 2 sends 2 of 5 bytes, then rst
        txmode = 0;
        do_reset(1);
        for (int b = 0; b < 5; b++) pq[2].push_back(9'((b == 4 ? 9'h100 : 9'h0) | 9'(8'hB0 + b)));
        drive();
        start = model_bytes; n = 0;
        while (model_bytes < start + 2 && n < 50) begin
            cycle();
            n++;
        end
        chk("rst_wait", 32'(model_bytes - start), 32'd2);
        pq[0].push_back(9'h1A5);
        drive();
        clear_hist();
        do_reset(1);
        cycle();
        cycle();
        chk("rst_grant_zero", 32'(h_grant[1]), 32'd0);
        chk("rst_busy_zero",  32'(h_busy[1]),  32'd0);
        chk("rst_restart",    32'(h_grant[2]), 32'h1);
        drain("rst_drain", 200);

        // Owner 0 stalls mid-packet while requester 3 waits
        do_reset(1);
        pq[0].push_back(9'h011); pq[0].push_back(9'h022);
        pq[3].push_back(9'h133);
        drive();
        clear_hist();
`ifdef UART_ARB_TIMEOUT_EN
        repeat (22) cycle();
        chk("wd_no_early", 32'(h_to[17]), 32'd0);
        chk("wd_pulse",    32'(h_to[18]), 32'd1);
        chk("wd_idle",     32'(h_grant[19]), 32'd0);
        chk("wd_regrant",  32'(h_grant[20]), 32'h8);
`else
        repeat (1001) cycle();
        hold_cnt = 0;
        for (int k = 1; k <= 1000; k++) if (h_grant[k] == 4'h1) hold_cnt++;
        chk("lock_hold", 32'(hold_cnt), 32'd1000);
`endif
        pq[0].push_back(9'h144);
        drive();
        drain("lock_drain", 300);

        // Randomized traffic
        do_reset(1);
        txmode = 1; vprob = 60;
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 3; p++) begin
                len = int'($urandom_range(5, 1));
                for (int b = 0; b < len; b++)
                    pq[i].push_back({(b == len - 1), 8'($urandom)});
            end
        end
        drive();
        drain("rand_drain", 5000);

        chk("byte_count", 32'(dut_bytes), 32'(model_bytes));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one byte-level UART transmit engine between `NUM_REQ` packet sources, such as a status banner, an RX echo path and a debug dumper. It sits between the requesters and the transmitter's byte handshake, driving `tx_valid`/`tx_data` and consuming `tx_ready`. A grant is held for a whole packet, so messages from different sources never interleave on the wire.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 2_700_000: stall limit in cycles (100 ms at 27 MHz). Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock (27 MHz).
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  marks the final byte of a packet; qualified by `req_valid`.
- `req_ready`  out  NUM_REQ  per-requester accept.
- `tx_valid`  out  1  byte valid to the UART engine.
- `tx_data`  out  8  byte to the UART engine.
- `tx_ready`  in  1  UART engine can accept a byte (high when its TX FSM is idle).
- `grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high while a packet is owned.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- A byte transfers on any cycle where valid and ready are both high.
  - A requester holds `req_valid`, `req_data` and `req_last` stable until accepted.
  - The engine may hold `tx_ready` high indefinitely.
- State machine states: `IDLE` and `SEND`.
- `IDLE`:
  - `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0.
  - If any `req_valid` is high, select the first requester at or after `rr_ptr` (wrapping modulo `NUM_REQ`), register it as `owner`, and go to `SEND`.
- `SEND`:
  - `grant`=onehot(owner), `busy`=1.
  - Combinational pass-through: `tx_valid`=`req_valid[owner]`, `tx_data`=owner's byte, `req_ready[owner]`=`tx_ready`; all other `req_ready` bits are 0.
  - A transfer with `req_last[owner]`=1 sets `rr_ptr`←(owner+1) mod `NUM_REQ` and returns to `IDLE`.
- Fairness: a requester that loses arbitration waits at most `NUM_REQ`-1 packets.
- Boundary conditions:
  - A single-byte packet (`req_last` on the first byte) is legal.
  - Deasserting `req_valid` mid-packet keeps the lock, subject to the watchdog if configured.
  - A non-owner's `req_valid` or `req_last` is ignored.
  - Pointer wrap: with owner=`NUM_REQ`-1, `rr_ptr` becomes 0.
- Reset (any cycle, including mid-packet):
  - Next state `IDLE`, `rr_ptr`=0, watchdog counter 0.
  - All outputs 0: `tx_valid`, `req_ready`, `grant`, `busy`, `timeout`.
  - A byte already in the UART engine completes there; the arbiter does not abort it.

## Timing
- Arbitration latency: `req_valid` rising in cycle N (state `IDLE`) gives `grant` and `tx_valid` in cycle N+1.
- Data path: zero-latency pass-through from requester to engine while in `SEND`.
- Inter-packet gap: exactly one `IDLE` cycle after each last-byte transfer, even when other requests are pending.
- Back-to-back bytes within a packet are limited only by `tx_ready`.

## Configuration
`UART_ARB_TIMEOUT_EN` adds a stall watchdog.

With the macro defined:
- A counter increments every `SEND` cycle with no transfer and clears on any transfer.
- When the counter reaches `TIMEOUT_CYCLES`-1:
  - `timeout` pulses for one cycle.
  - The state returns to `IDLE`.
  - `rr_ptr`←owner+1.
  - The owner's remaining bytes are treated as a new packet at its next grant.
- Counter width: $clog2(`TIMEOUT_CYCLES`).

Without the macro:
- No counter is built.
- `timeout` is tied to 0.
- The lock holds until `req_last`.

## Structure
- Shared package `uart_pkg`:
  - State enum (`IDLE`, `SEND`).
  - `UART_BYTE_W`=8.
  - Default `CLK_HZ`=27_000_000 and `BAUD`=115200, used to derive `TIMEOUT_CYCLES`.
- Sub-module `rr_select`: combinational rotate-priority pick. It takes `req_valid` and `rr_ptr` and returns the winner index and an `any` flag. `uart_tx_arbiter` holds the FSM, owner and pointer registers, the mux and the watchdog.

## Test plan
- Single source: requester 1 sends "Hi\n" (`req_last` on `0x0A`) with `tx_ready` always 1 → `grant`=4'b0010 from the cycle after `req_valid`; `tx_data` sequence `0x48`, `0x69`, `0x0A` on consecutive cycles; `busy` falls the cycle after `0x0A`.
- Round robin: all four requesters valid with 2-byte packets from reset → grant order 0, 1, 2, 3, 0; exactly one `IDLE` cycle between packets.
- Backpressure: `tx_ready` high for 1 cycle in every 234 → `req_ready[owner]` mirrors `tx_ready`; no byte is duplicated or dropped; non-owner `req_ready` bits stay 0 throughout.
- Reset mid-packet: assert `rst` for 1 cycle after byte 2 of 5 from requester 2 → next cycle `grant`=0 and `busy`=0; the following arbitration starts from requester 0.
- Watchdog (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): owner 0 drops `req_valid` mid-packet while requester 3 waits → `timeout` pulses after 16 stalled cycles; after one `IDLE` cycle `grant`=4'b1000. Without the macro, `grant` stays 4'b0001 for 1000 cycles.
